// File: rtl/capture_buffer_ctrl.sv
// Capture DEPTH ADC samples into a local buffer, then stream them oldest-first to the Arduino writer.
// Outputs are registered; each handshake waits indefinitely on adc_valid/tx_done. Optional CAPTURE_CHECKSUM_EN appends a wrapped-sum word.
module capture_buffer_ctrl #(
   parameter int SAMPLE_W = 12,
   parameter int DEPTH    = 100,
   parameter int CNT_W    = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                adc_req,
   input  logic                adc_valid,
   input  logic [SAMPLE_W-1:0] adc_data,
   output logic                tx_req,
   output logic [SAMPLE_W-1:0] tx_data,
   input  logic                tx_done,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH);

   typedef enum logic [2:0] {IDLE, CAP, CAP_GAP, SEND, SEND_GAP, DONE} state_t;

   state_t              state;
   logic [CNT_W-1:0]    rd_ptr;
   logic [SAMPLE_W-1:0] mem [DEPTH];
`ifdef CAPTURE_CHECKSUM_EN
   logic [SAMPLE_W-1:0] csum;
   logic                csum_sent;
`endif

   // Buffer contents survive reset and restart; only the pointers are cleared.
   always_ff @(posedge clk) begin
      if (state == CAP && adc_valid)
         mem[count[AW-1:0]] <= adc_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         adc_req   <= 1'b0;
         tx_req    <= 1'b0;
         tx_data   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         count     <= '0;
         rd_ptr    <= '0;
`ifdef CAPTURE_CHECKSUM_EN
         csum      <= '0;
         csum_sent <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= CAP;
                  adc_req   <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  count     <= '0;
                  rd_ptr    <= '0;
`ifdef CAPTURE_CHECKSUM_EN
                  csum      <= '0;
                  csum_sent <= 1'b0;
`endif
               end
            end
            CAP: begin
               if (adc_valid) begin
                  count   <= count + CNT_W'(1);
                  adc_req <= 1'b0;
                  state   <= CAP_GAP;
`ifdef CAPTURE_CHECKSUM_EN
                  csum    <= csum + adc_data;
`endif
               end
            end
            CAP_GAP: begin
               if (count < LAST) begin
                  adc_req <= 1'b1;
                  state   <= CAP;
               end else begin
                  tx_data <= mem[rd_ptr[AW-1:0]];
                  tx_req  <= 1'b1;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (tx_done) begin
                  tx_req <= 1'b0;
                  state  <= SEND_GAP;
                  // rd_ptr parks at DEPTH while the checksum word goes out
                  if (rd_ptr < LAST)
                     rd_ptr <= rd_ptr + CNT_W'(1);
               end
            end
            SEND_GAP: begin
`ifdef CAPTURE_CHECKSUM_EN
               if (rd_ptr < LAST) begin
                  tx_data <= mem[rd_ptr[AW-1:0]];
                  tx_req  <= 1'b1;
                  state   <= SEND;
               end else if (!csum_sent) begin
                  tx_data   <= csum;
                  tx_req    <= 1'b1;
                  csum_sent <= 1'b1;
                  state     <= SEND;
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
`else
               if (rd_ptr < LAST) begin
                  tx_data <= mem[rd_ptr[AW-1:0]];
                  tx_req  <= 1'b1;
                  state   <= SEND;
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Randomized bench for capture_buffer_ctrl: expected transmit stream is a queue built from the captured samples.
module tb_capture_buffer_ctrl;

   localparam int SW = 12;
   localparam int D  = 4;
   localparam int CW = 3;

   typedef logic [SW-1:0] smp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          adc_req;
   logic          adc_valid;
   logic [SW-1:0] adc_data;
   logic          tx_req;
   logic [SW-1:0] tx_data;
   logic          tx_done;
   logic          busy;
   logic          done;
   logic [CW-1:0] count;

   int   passed = 0;
   int   total  = 0;
   smp_t samples [D];
   smp_t exp_q [$];
   smp_t last_word;

   capture_buffer_ctrl #(.SAMPLE_W(SW), .DEPTH(D), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .adc_req   (adc_req),
      .adc_valid (adc_valid),
      .adc_data  (adc_data),
      .tx_req    (tx_req),
      .tx_data   (tx_data),
      .tx_done   (tx_done),
      .busy      (busy),
      .done      (done),
      .count     (count)
   );

   always #10 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected stream: samples in capture order, plus their wrapped sum when the checksum build is used.
   task automatic build_model;
      smp_t sum;
      sum = '0;
      exp_q.delete();
      for (int i = 0; i < D; i++) begin
         exp_q.push_back(samples[i]);
         sum = sum + samples[i];
      end
`ifdef CAPTURE_CHECKSUM_EN
      exp_q.push_back(sum);
`endif
   endtask

   task automatic randomize_samples;
      for (int i = 0; i < D; i++) samples[i] = SW'($urandom);
   endtask

   task automatic wait_adc_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (adc_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         total++;
         $display("FAIL adc_req_timeout: adc_req=%b after 50 cycles, required 1", adc_req);
      end
   endtask

   task automatic wait_tx_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (tx_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         total++;
         $display("FAIL tx_req_timeout: tx_req=%b after 50 cycles, required 1", tx_req);
      end
   endtask

   task automatic do_start;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({adc_req, busy, done, count} !== {1'b1, 1'b1, 1'b0, CW'(0)}) begin
         $display("FAIL start_state: adc_req/busy/done/count=%b/%b/%b/%0d required 1/1/0/0",
                  adc_req, busy, done, count);
      end else passed++;
   endtask

   task automatic do_capture(input bit spur);
      bit            ok;
      logic [CW-1:0] c0;
      for (int i = 0; i < D; i++) begin
         wait_adc_req(ok);
         if (!ok) return;
         if (spur) begin
            c0 = count;
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            total++;
            if ({adc_req, tx_req, count} !== {1'b1, 1'b0, c0}) begin
               $display("FAIL spur_tx_done_in_cap: adc_req/tx_req/count=%b/%b/%0d required 1/0/%0d",
                        adc_req, tx_req, count, c0);
            end else passed++;
            start = 1'b1;
            tick();
            start = 1'b0;
            total++;
            if ({busy, done, adc_req, count} !== {1'b1, 1'b0, 1'b1, c0}) begin
               $display("FAIL spur_start_in_cap: busy/done/adc_req/count=%b/%b/%b/%0d required 1/0/1/%0d",
                        busy, done, adc_req, count, c0);
            end else passed++;
         end
         repeat ($urandom_range(0, 2)) tick();
         adc_valid = 1'b1;
         adc_data  = samples[i];
         tx_done   = 1'($urandom_range(0, 1));
         tick();
         adc_valid = 1'b0;
         tx_done   = 1'b0;
         adc_data  = SW'($urandom);
         total++;
         if ({count, adc_req, tx_req} !== {CW'(i + 1), 1'b0, 1'b0}) begin
            $display("FAIL capture_step: count/adc_req/tx_req=%0d/%b/%b required %0d/0/0",
                     count, adc_req, tx_req, i + 1);
         end else passed++;
      end
   endtask

   task automatic do_send(input int n, input bit spur);
      bit   ok;
      smp_t exp;
      for (int k = 0; k < n; k++) begin
         wait_tx_req(ok);
         if (!ok) return;
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL extra_word: tx_data=%h sent, required no further word", tx_data);
            return;
         end
         exp = exp_q.pop_front();
         if (tx_data !== exp) begin
            $display("FAIL tx_word%0d: tx_data=%h required %h", k, tx_data, exp);
         end else passed++;
         last_word = tx_data;
         repeat ($urandom_range(0, 2)) tick();
         if (spur) begin
            adc_valid = 1'b1;
            adc_data  = SW'($urandom);
            start     = 1'b1;
            tick();
            adc_valid = 1'b0;
            start     = 1'b0;
            total++;
            if ({tx_req, tx_data, count, adc_req, busy} !== {1'b1, exp, CW'(D), 1'b0, 1'b1}) begin
               $display("FAIL spur_in_send: tx_req/tx_data/count/adc_req/busy=%b/%h/%0d/%b/%b required 1/%h/%0d/0/1",
                        tx_req, tx_data, count, adc_req, busy, exp, D);
            end else passed++;
         end
         tx_done   = 1'b1;
         adc_valid = 1'($urandom_range(0, 1));
         adc_data  = SW'($urandom);
         tick();
         tx_done   = 1'b0;
         adc_valid = 1'b0;
         total++;
         if ({tx_req, count} !== {1'b0, CW'(D)}) begin
            $display("FAIL tx_release: tx_req/count=%b/%0d required 0/%0d", tx_req, count, D);
         end else passed++;
      end
   endtask

   task automatic check_done;
      for (int i = 0; i < 10; i++) begin
         if (done) break;
         if (tx_req) begin
            total++;
            $display("FAIL extra_word: tx_req=1 tx_data=%h before done, required done", tx_data);
            break;
         end
         tick();
      end
      total++;
      if ({done, busy, adc_req, tx_req, count} !== {1'b1, 1'b0, 1'b0, 1'b0, CW'(D)}) begin
         $display("FAIL done_state: done/busy/adc_req/tx_req/count=%b/%b/%b/%b/%0d required 1/0/0/0/%0d",
                  done, busy, adc_req, tx_req, count, D);
      end else passed++;
      total++;
      if (exp_q.size() != 0) begin
         $display("FAIL words_outstanding: %0d words unsent, required 0", exp_q.size());
      end else passed++;
   endtask

   task automatic full_run(input bit spur);
      build_model();
      do_start();
      do_capture(spur);
      do_send(exp_q.size(), spur);
      check_done();
   endtask

   task automatic check_outputs_zero(input string tag);
      total++;
      if ({adc_req, tx_req, tx_data, busy, done, count} !== '0) begin
         $display("FAIL %s: adc_req/tx_req/tx_data/busy/done/count=%b/%b/%h/%b/%b/%0d required all 0",
                  tag, adc_req, tx_req, tx_data, busy, done, count);
      end else passed++;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #5;
      check_outputs_zero("reset_state");
      tick();
      tick();
      rst = 1'b1;
      tick();
      check_outputs_zero("idle_after_release");
   endtask

   task automatic test_basic;
      for (int i = 0; i < D; i++) samples[i] = SW'(i + 1);
      full_run(1'b0);
   endtask

   task automatic test_checksum;
`ifdef CAPTURE_CHECKSUM_EN
      samples[0] = 12'hFFF;
      samples[1] = 12'h002;
      samples[2] = 12'h010;
      samples[3] = 12'h100;
      full_run(1'b0);
      total++;
      if (last_word !== 12'h111) begin
         $display("FAIL checksum_word: last tx_data=%h required 111", last_word);
      end else passed++;
`endif
   endtask

   task automatic test_handshake_timing;
      bit ok;
      randomize_samples();
      build_model();
      do_start();
      for (int i = 0; i < D; i++) begin
         wait_adc_req(ok);
         if (!ok) return;
         repeat ($urandom_range(0, 3)) tick();
         adc_valid = 1'b1;
         adc_data  = samples[i];
         tick();
         adc_valid = 1'b0;
         total++;
         if ({adc_req, tx_req} !== 2'b00) begin
            $display("FAIL gap_cycle%0d: adc_req/tx_req=%b/%b required 0/0", i, adc_req, tx_req);
         end else passed++;
         tick();
         total++;
         if (i < D - 1) begin
            if ({adc_req, tx_req} !== 2'b10) begin
               $display("FAIL rerequest%0d: adc_req/tx_req=%b/%b required 1/0", i, adc_req, tx_req);
            end else passed++;
         end else begin
            if ({tx_req, tx_data, adc_req} !== {1'b1, samples[0], 1'b0}) begin
               $display("FAIL first_tx_timing: tx_req/tx_data/adc_req=%b/%h/%b required 1/%h/0",
                        tx_req, tx_data, adc_req, samples[0]);
            end else passed++;
         end
      end
      do_send(exp_q.size(), 1'b0);
      check_done();
   endtask

   task automatic test_spurious;
      randomize_samples();
      full_run(1'b1);
   endtask

   task automatic test_reset_mid_send;
      randomize_samples();
      build_model();
      do_start();
      do_capture(1'b0);
      do_send(2, 1'b0);
      repeat ($urandom_range(0, 1)) tick();
      #3;
      rst = 1'b0;
      #1;
      check_outputs_zero("reset_mid_send");
      tick();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if ({tx_req, busy, done, adc_req} !== 4'b0000) begin
            $display("FAIL no_resume: tx_req/busy/done/adc_req=%b/%b/%b/%b required 0/0/0/0",
                     tx_req, busy, done, adc_req);
         end else passed++;
      end
      randomize_samples();
      full_run(1'b0);
   endtask

   task automatic test_restart;
      for (int i = 0; i < D; i++) samples[i] = SW'(12'h0AA + i);
      full_run(1'b0);
   endtask

   task automatic test_random_runs;
      for (int r = 0; r < 6; r++) begin
         randomize_samples();
         full_run(1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      adc_valid = 1'b0;
      adc_data  = '0;
      tx_done   = 1'b0;
      last_word = '0;
      test_reset();
      test_basic();
      test_checksum();
      test_handshake_timing();
      test_spurious();
      test_reset_mid_send();
      test_restart();
      test_random_runs();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation exceeded time limit, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/capture_buffer_ctrl.md
CAPTURE_BUFFER_CTRL -- requirements
Module: capture_buffer_ctrl

Interface
REQ-001 Parameter SAMPLE_W, default 12, sample width in bits (legal 1..32).
REQ-002 Parameter DEPTH, default 100, samples per capture (legal 2..1024).
REQ-003 Parameter CNT_W, default 7, counter width; SHALL satisfy 2^CNT_W > DEPTH.
REQ-004 clk  input  1  system clock (50 MHz); all state changes on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 start  input  1  level-sampled capture request; honoured only in IDLE or DONE.
REQ-007 adc_req  output  1  request to ADC reader; high while a sample is wanted.
REQ-008 adc_valid  input  1  one-cycle pulse, adc_data valid; ignored while adc_req low.
REQ-009 adc_data  input  SAMPLE_W  sample from ADC reader.
REQ-010 tx_req  output  1  request to Arduino writer; high while tx_data is being sent.
REQ-011 tx_data  output  SAMPLE_W  word being sent; stable while tx_req high.
REQ-012 tx_done  input  1  one-cycle pulse, word accepted; ignored while tx_req low.
REQ-013 busy  output  1  high in any state except IDLE and DONE.
REQ-014 done  output  1  high in DONE only.
REQ-015 count  output  CNT_W  samples captured in the current/last run.

Function
REQ-016 FSM states: IDLE, CAP, CAP_GAP, SEND, SEND_GAP, DONE; all outputs registered.
REQ-017 IDLE/DONE with start=1 at edge N: clear count and pointers, enter CAP; adc_req=1 from N+1.
REQ-018 CAP with adc_valid=1 at edge M: write adc_data to buffer[count], count+1, adc_req=0 from M+1, enter CAP_GAP.
REQ-019 CAP_GAP lasts exactly one cycle; then CAP (adc_req=1) if count<DEPTH, else SEND.
REQ-020 Buffer SHALL be DEPTH x SAMPLE_W registers/RAM; contents not cleared by reset or start.
REQ-021 SEND: tx_data = buffer[rd_ptr] loaded on entry, tx_req=1 held until tx_done.
REQ-022 tx_done at edge K: tx_req=0 from K+1, rd_ptr+1, enter SEND_GAP for exactly one cycle.
REQ-023 Transmit order oldest-first: buffer[0] first, buffer[DEPTH-1] last.
REQ-024 Last adc_valid at edge M: tx_req=1 with tx_data=buffer[0] from M+2.
REQ-025 After final word's SEND_GAP: enter DONE; done=1, busy=0; hold until start or reset.
REQ-026 start while busy SHALL be ignored; no effect on counters or outputs.
REQ-027 adc_valid and tx_done asserted simultaneously: only the one matching current state acts.
REQ-028 rd_ptr and count SHALL never exceed DEPTH; no wrap-around within a run.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, adc_req=0, tx_req=0, tx_data=0, busy=0, done=0, count=0, pointers=0.
REQ-030 Reset mid-capture or mid-send SHALL abort the run; no partial transmission resumes after release.
REQ-031 First start after reset release SHALL behave per REQ-017.

Configuration
REQ-032 Macro CAPTURE_CHECKSUM_EN: defined -> after buffer[DEPTH-1], one extra SEND/SEND_GAP word carrying sum of all DEPTH samples modulo 2^SAMPLE_W, then DONE.
REQ-033 Checksum accumulator cleared on start, updated on each accepted adc_valid.
REQ-034 Macro undefined -> no checksum logic; exactly DEPTH words sent, then DONE.

Verification (SAMPLE_W=12, DEPTH=4)
REQ-035 Basic: start, samples 0x001,0x002,0x003,0x004, tx_done after each tx_req -> tx_data sequence 0x001,0x002,0x003,0x004, done=1, count=4.
REQ-036 Checksum (macro defined): samples 0xFFF,0x002,0x010,0x100 -> 5th word 0x111 (wrapped sum), then done=1.
REQ-037 Handshake timing: adc_valid at cycle 10 -> adc_req low at 11, high at 12; last adc_valid at cycle 40 -> tx_req high at 42, tx_data=first sample.
REQ-038 Spurious inputs: adc_valid pulses during SEND, tx_done during CAP, start during busy -> no state, count or data change.
REQ-039 Reset mid-send after 2 words: rst=0 -> all outputs 0 same cycle; new start yields fresh 4-sample capture and send.
REQ-040 Restart from DONE: second start with samples 0x0AA..0x0AD -> count=4, second transmission carries only new samples.
